// File: rtl/dmem_arbiter_if.sv
// Requester and dmem-side signal bundle for the two-master data-memory arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              r0_req_i, r0_we_i, r0_lock_i;
  logic [2:0]        r0_op_i;
  logic [ADDR_W-1:0] r0_addr_i;
  logic [31:0]       r0_wdata_i;
  logic              r0_gnt_o, r0_rvalid_o, r0_err_o;
  logic [31:0]       r0_rdata_o;

  logic              r1_req_i, r1_we_i, r1_lock_i;
  logic [2:0]        r1_op_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [31:0]       r1_wdata_i;
  logic              r1_gnt_o, r1_rvalid_o, r1_err_o;
  logic [31:0]       r1_rdata_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_st_data_o;
  logic              mem_st_en_o;
  logic              mem_sb_en_o, mem_sh_en_o, mem_sw_en_o;
  logic              mem_lb_en_o, mem_lh_en_o, mem_lw_en_o, mem_lbu_en_o, mem_lhu_en_o;
  logic [31:0]       mem_ld_data_i;

  modport slave (
    input  r0_req_i, r0_we_i, r0_lock_i, r0_op_i, r0_addr_i, r0_wdata_i,
    output r0_gnt_o, r0_rvalid_o, r0_err_o, r0_rdata_o,
    input  r1_req_i, r1_we_i, r1_lock_i, r1_op_i, r1_addr_i, r1_wdata_i,
    output r1_gnt_o, r1_rvalid_o, r1_err_o, r1_rdata_o,
    output mem_addr_o, mem_st_data_o, mem_st_en_o,
    output mem_sb_en_o, mem_sh_en_o, mem_sw_en_o,
    output mem_lb_en_o, mem_lh_en_o, mem_lw_en_o, mem_lbu_en_o, mem_lhu_en_o,
    input  mem_ld_data_i
  );

  modport master (
    output r0_req_i, r0_we_i, r0_lock_i, r0_op_i, r0_addr_i, r0_wdata_i,
    input  r0_gnt_o, r0_rvalid_o, r0_err_o, r0_rdata_o,
    output r1_req_i, r1_we_i, r1_lock_i, r1_op_i, r1_addr_i, r1_wdata_i,
    input  r1_gnt_o, r1_rvalid_o, r1_err_o, r1_rdata_o,
    input  mem_addr_o, mem_st_data_o, mem_st_en_o,
    input  mem_sb_en_o, mem_sh_en_o, mem_sw_en_o,
    input  mem_lb_en_o, mem_lh_en_o, mem_lw_en_o, mem_lbu_en_o, mem_lhu_en_o,
    output mem_ld_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single dmem/MMIO port: IDLE -> ACCESS -> RESP,
// with lock-based ownership, op/alignment checking and a registered response.
module dmem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  bus
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic              we;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              lock;
  } req_t;

  state_e                    state_q, state_d;
  req_t [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ-1:0]        req_v, gnt, rvalid;
  logic [NUM_REQ-1:0][31:0]  rdata;
  req_t                      lat;
  logic                      lat_id, lat_err, last_id;
  logic [31:0]               rdata_q;
  logic                      win_id, win_v, gnt_any, err_in;

  assign req_v     = {bus.r1_req_i, bus.r0_req_i};
  assign req_in[0] = '{we: bus.r0_we_i, op: bus.r0_op_i, addr: bus.r0_addr_i,
                       wdata: bus.r0_wdata_i, lock: bus.r0_lock_i};
  assign req_in[1] = '{we: bus.r1_we_i, op: bus.r1_op_i, addr: bus.r1_addr_i,
                       wdata: bus.r1_wdata_i, lock: bus.r1_lock_i};

  function automatic logic op_err(input logic we, input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000:  op_err = 1'b0;
      3'b001:  op_err = a[0];
      3'b010:  op_err = |a;
      3'b100:  op_err = we;
      3'b101:  op_err = we | a[0];
      default: op_err = 1'b1;
    endcase
  endfunction

  // A locked owner that is still requesting wins outright; otherwise normal tie-break.
  always_comb begin
    win_v  = |req_v;
    win_id = 1'b0;
    if (lat.lock && req_v[lat_id])
      win_id = lat_id;
    else if (&req_v)
      win_id = FIXED_PRIO ? 1'b0 : ~last_id;
    else
      win_id = req_v[1] & ~req_v[0];
  end

  assign gnt_any = rst_ni && (state_q == IDLE) && win_v;
  assign err_in  = op_err(req_in[win_id].we, req_in[win_id].op, req_in[win_id].addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = err_in ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lat     <= '0;
      lat_id  <= 1'b0;
      lat_err <= 1'b0;
      last_id <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        lat     <= req_in[win_id];
        lat_id  <= win_id;
        lat_err <= err_in;
        last_id <= win_id;
        rdata_q <= '0;
      end else if (state_q == IDLE && lat.lock && !req_v[lat_id]) begin
        lat.lock <= 1'b0;
      end
      if (state_q == ACCESS && !lat.we)
        rdata_q <= bus.mem_ld_data_i;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign gnt[i]    = gnt_any && (win_id == 1'(i));
    assign rvalid[i] = (state_q == RESP) && (lat_id == 1'(i));
    assign rdata[i]  = rvalid[i] ? rdata_q : '0;
  end

  assign bus.r0_gnt_o    = gnt[0];
  assign bus.r1_gnt_o    = gnt[1];
  assign bus.r0_rvalid_o = rvalid[0];
  assign bus.r1_rvalid_o = rvalid[1];
  assign bus.r0_rdata_o  = rdata[0];
  assign bus.r1_rdata_o  = rdata[1];
  assign bus.r0_err_o    = rvalid[0] & lat_err;
  assign bus.r1_err_o    = rvalid[1] & lat_err;

  // Erroneous ops never reach ACCESS, so only legal encodings decode here.
  logic st, ld;
  assign st = (state_q == ACCESS) &  lat.we;
  assign ld = (state_q == ACCESS) & ~lat.we;

  assign bus.mem_addr_o    = lat.addr;
  assign bus.mem_st_data_o = lat.wdata;
  assign bus.mem_st_en_o   = st;
  assign bus.mem_sb_en_o   = st && lat.op == 3'b000;
  assign bus.mem_sh_en_o   = st && lat.op == 3'b001;
  assign bus.mem_sw_en_o   = st && lat.op == 3'b010;
  assign bus.mem_lb_en_o   = ld && lat.op == 3'b000;
  assign bus.mem_lh_en_o   = ld && lat.op == 3'b001;
  assign bus.mem_lw_en_o   = ld && lat.op == 3'b010;
  assign bus.mem_lbu_en_o  = ld && lat.op == 3'b100;
  assign bus.mem_lhu_en_o  = ld && lat.op == 3'b101;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed dmem model,
// an io_hex0 register at 0x800 and a fixed io_sw value at 0x900.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();
  dmem_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // dmem model
  logic [7:0]  mem [0:2047];
  logic [31:0] hex0;
  logic [31:0] a, aw, w, b8, h16;
  logic [8:0]  en;

  assign en = {bus.mem_st_en_o, bus.mem_sb_en_o, bus.mem_sh_en_o, bus.mem_sw_en_o,
               bus.mem_lb_en_o, bus.mem_lh_en_o, bus.mem_lw_en_o, bus.mem_lbu_en_o,
               bus.mem_lhu_en_o};

  always_comb begin
    a   = bus.mem_addr_o;
    aw  = {a[31:2], 2'b00};
    w   = '0;
    if (aw == 32'h800)      w = hex0;
    else if (aw == 32'h900) w = 32'h0000A5F0;
    else if (aw < 32'h800)  w = {mem[aw[10:0]+3], mem[aw[10:0]+2], mem[aw[10:0]+1], mem[aw[10:0]]};
    b8  = w >> {a[1:0], 3'b000};
    h16 = w >> {a[1], 4'b0000};
    bus.mem_ld_data_i = '0;
    if (bus.mem_lw_en_o)  bus.mem_ld_data_i = w;
    if (bus.mem_lh_en_o)  bus.mem_ld_data_i = {{16{h16[15]}}, h16[15:0]};
    if (bus.mem_lhu_en_o) bus.mem_ld_data_i = {16'h0, h16[15:0]};
    if (bus.mem_lb_en_o)  bus.mem_ld_data_i = {{24{b8[7]}}, b8[7:0]};
    if (bus.mem_lbu_en_o) bus.mem_ld_data_i = {24'h0, b8[7:0]};
  end

  always @(posedge clk) begin
    logic [3:0]  be;
    logic [31:0] wd, wa;
    if (bus.mem_st_en_o) begin
      wa = {bus.mem_addr_o[31:2], 2'b00};
      be = bus.mem_sw_en_o ? 4'hF :
           bus.mem_sh_en_o ? (4'b0011 << {bus.mem_addr_o[1], 1'b0}) :
           bus.mem_sb_en_o ? (4'b0001 << bus.mem_addr_o[1:0]) : 4'h0;
      wd = bus.mem_st_data_o << {bus.mem_addr_o[1:0], 3'b000};
      for (int k = 0; k < 4; k++)
        if (be[k]) begin
          if (wa == 32'h800)     hex0[8*k +: 8] = wd[8*k +: 8];
          else if (wa < 32'h800) mem[wa[10:0] + k] = wd[8*k +: 8];
        end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic req, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    if (id == 0) begin
      bus.r0_req_i = req; bus.r0_we_i = we; bus.r0_op_i = op;
      bus.r0_addr_i = addr; bus.r0_wdata_i = wdata; bus.r0_lock_i = lock;
    end else begin
      bus.r1_req_i = req; bus.r1_we_i = we; bus.r1_op_i = op;
      bus.r1_addr_i = addr; bus.r1_wdata_i = wdata; bus.r1_lock_i = lock;
    end
  endtask

  // Called shortly after a rising edge in IDLE with requests already driven.
  task automatic run_txn(input string tag, input int id, input logic [8:0] exp_en,
                         input logic [31:0] exp_addr, input logic exp_err,
                         input logic [31:0] exp_rdata);
    #1;
    check({tag, ".gnt"}, {30'h0, bus.r1_gnt_o, bus.r0_gnt_o}, (id == 0) ? 32'h1 : 32'h2);
    @(posedge clk); #1;
    if (!exp_err) begin
      check({tag, ".en"},   {23'h0, en}, {23'h0, exp_en});
      check({tag, ".addr"}, bus.mem_addr_o, exp_addr);
      check({tag, ".early_rvalid"}, {30'h0, bus.r1_rvalid_o, bus.r0_rvalid_o}, 32'h0);
      @(posedge clk); #1;
    end
    check({tag, ".resp_en"}, {23'h0, en}, 32'h0);
    check({tag, ".rvalid"}, {30'h0, bus.r1_rvalid_o, bus.r0_rvalid_o}, (id == 0) ? 32'h1 : 32'h2);
    check({tag, ".err"},   {31'h0, (id == 0) ? bus.r0_err_o : bus.r1_err_o}, {31'h0, exp_err});
    check({tag, ".rdata"}, (id == 0) ? bus.r0_rdata_o : bus.r1_rdata_o, exp_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    hex0  = 32'h0;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
    #2;
    check("rst.gnt",    {30'h0, bus.r1_gnt_o, bus.r0_gnt_o}, 32'h0);
    check("rst.rvalid", {30'h0, bus.r1_rvalid_o, bus.r0_rvalid_o}, 32'h0);
    check("rst.en",     {23'h0, en}, 32'h0);
    check("rst.addr",   bus.mem_addr_o, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ties alternate starting with r0
    drive(0, 1'b1, 1'b0, 3'b010, 32'h900, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 3'b000, 32'h900, 32'h0, 1'b0);
    run_txn("tie0", 0, 9'h004, 32'h900, 1'b0, 32'h0000A5F0);
    run_txn("tie1", 1, 9'h010, 32'h900, 1'b0, 32'hFFFFFFF0);
    run_txn("tie2", 0, 9'h004, 32'h900, 1'b0, 32'h0000A5F0);

    // lock: r1 keeps ownership for its SB although r0 would win the tie
    drive(1, 1'b1, 1'b1, 3'b010, 32'h800, 32'h12345611, 1'b1);
    run_txn("lk_sw", 1, 9'h120, 32'h800, 1'b0, 32'h0);
    drive(1, 1'b1, 1'b1, 3'b000, 32'h800, 32'h0000005A, 1'b0);
    run_txn("lk_sb", 1, 9'h180, 32'h800, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    run_txn("lk_r0", 0, 9'h004, 32'h900, 1'b0, 32'h0000A5F0);
    check("lk.hex0", hex0, 32'h1234565A);

    // single store / load
    drive(0, 1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    run_txn("sw", 0, 9'h120, 32'h10, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    run_txn("lw", 0, 9'h004, 32'h10, 1'b0, 32'hDEADBEEF);

    // errors
    drive(0, 1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 1'b0);
    run_txn("e_lh", 0, 9'h0, 32'h0, 1'b1, 32'h0);
    drive(0, 1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 1'b0);
    run_txn("e_lw", 0, 9'h0, 32'h0, 1'b1, 32'h0);
    drive(0, 1'b1, 1'b1, 3'b100, 32'h10, 32'h55, 1'b0);
    run_txn("e_sbu", 0, 9'h0, 32'h0, 1'b1, 32'h0);
    drive(0, 1'b1, 1'b0, 3'b111, 32'h10, 32'h0, 1'b0);
    run_txn("e_op7", 0, 9'h0, 32'h0, 1'b1, 32'h0);
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    run_txn("e_mem", 0, 9'h004, 32'h10, 1'b0, 32'hDEADBEEF);

    // unsigned loads from io_sw
    drive(0, 1'b1, 1'b0, 3'b100, 32'h900, 32'h0, 1'b0);
    run_txn("lbu", 0, 9'h002, 32'h900, 1'b0, 32'h000000F0);
    drive(0, 1'b1, 1'b0, 3'b101, 32'h900, 32'h0, 1'b0);
    run_txn("lhu", 0, 9'h001, 32'h900, 1'b0, 32'h0000A5F0);

    // reset in the middle of a store's ACCESS cycle
    drive(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0);
    #1;
    check("mr.gnt", {31'h0, bus.r0_gnt_o}, 32'h1);
    @(posedge clk); #1;
    check("mr.acc_en", {23'h0, en}, 32'h120);
    rst_n = 1'b0;
    #1;
    check("mr.en",    {23'h0, en}, 32'h0);
    check("mr.addr",  bus.mem_addr_o, 32'h0);
    check("mr.sdata", bus.mem_st_data_o, 32'h0);
    check("mr.gnt0",  {31'h0, bus.r0_gnt_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    run_txn("mr_lw", 0, 9'h004, 32'h20, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
